// File: rtl/crossbar_nxn_rr.sv
// N x N registered crossbar; each output has a round-robin arbiter and a one-entry output register.
// Latency: 1 cycle from accepted input word to out_valid.
// Backpressure: a full output whose out_ready is low grants nothing, so its requesters see in_ready=0.
//
// Ports:
//   clk, rst            rising-edge clock, synchronous active-high reset
//   in_data/in_dest     per-input word and destination output index (port i at [i*W +: W] / [i*SEL_W +: SEL_W])
//   in_valid/in_ready   per-input handshake; a transfer occurs when both are high at a clock edge
//   out_data/out_src    per-output registered word and the index of the input that supplied it
//   out_valid/out_ready per-output handshake; a pop and a push in the same cycle replace the word with no bubble
module crossbar_nxn_rr #(
    parameter int SEL_W = 2,
    parameter int W     = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [(2**SEL_W)*W-1:0]       in_data,
    input  logic [(2**SEL_W)*SEL_W-1:0]   in_dest,
    input  logic [(2**SEL_W)-1:0]         in_valid,
    output logic [(2**SEL_W)-1:0]         in_ready,
    output logic [(2**SEL_W)*W-1:0]       out_data,
    output logic [(2**SEL_W)*SEL_W-1:0]   out_src,
    output logic [(2**SEL_W)-1:0]         out_valid,
    input  logic [(2**SEL_W)-1:0]         out_ready
);
    localparam int N = 2**SEL_W;

    logic [SEL_W-1:0] ptr     [N];
    logic [W-1:0]     data_q  [N];
    logic [SEL_W-1:0] src_q   [N];
    logic [N-1:0]     vld_q;

    logic [N-1:0]     gnt_vld;
    logic [SEL_W-1:0] gnt_idx [N];

    // Per-output arbitration. The search index is SEL_W bits wide, so ptr + k
    // wraps mod N on its own. An output that is full and not being drained
    // grants nothing, which is what stalls its requesters.
    always_comb begin
        logic [SEL_W-1:0] idx;
        logic             found;
        idx   = '0;
        found = 1'b0;
        for (int j = 0; j < N; j++) begin
            gnt_vld[j] = 1'b0;
            gnt_idx[j] = '0;
            found      = 1'b0;
            if (!vld_q[j] || out_ready[j]) begin
                for (int k = 0; k < N; k++) begin
                    idx = ptr[j] + SEL_W'(k);
                    if (!found && in_valid[idx] &&
                        (in_dest[idx*SEL_W +: SEL_W] == SEL_W'(j))) begin
                        found      = 1'b1;
                        gnt_vld[j] = 1'b1;
                        gnt_idx[j] = idx;
                    end
                end
            end
        end
    end

    // An input targets exactly one output, so it only needs to look at the
    // grant of its own destination.
    always_comb begin
        logic [SEL_W-1:0] dst;
        dst = '0;
        for (int i = 0; i < N; i++) begin
            dst         = in_dest[i*SEL_W +: SEL_W];
            in_ready[i] = !rst && gnt_vld[dst] && (gnt_idx[dst] == SEL_W'(i));
        end
    end

    always_comb begin
        for (int j = 0; j < N; j++) begin
            out_data[j*W +: W]         = data_q[j];
            out_src[j*SEL_W +: SEL_W]  = src_q[j];
        end
        out_valid = vld_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int j = 0; j < N; j++) begin
                ptr[j]    <= '0;
                data_q[j] <= '0;
                src_q[j]  <= '0;
            end
            vld_q <= '0;
        end else begin
            for (int j = 0; j < N; j++) begin
                if (gnt_vld[j]) begin
                    data_q[j] <= in_data[gnt_idx[j]*W +: W];
                    src_q[j]  <= gnt_idx[j];
                    vld_q[j]  <= 1'b1;
                    ptr[j]    <= gnt_idx[j] + 1'b1;
                end else if (out_ready[j]) begin
                    vld_q[j] <= 1'b0;
                end
            end
        end
    end
endmodule

// File: doc/crossbar_nxn_rr.md
Name: crossbar_nxn_rr

Overview:
- Parametrised N x N registered crossbar switch; successor to the fixed 4x4 4-bit combinational crossbar.
- Each input carries a W-bit word with an explicit destination index and a valid/ready handshake.
- Each output has its own round-robin arbiter, a one-entry output register and a ready input for backpressure.
- Used as the packet-routing fabric between lab datapath stages.

Parameters:
- SEL_W, 2, width of a port index; port count N = 2**SEL_W (derived localparam, default 4).
- W, 4, data width per port in bits.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous active-high reset.
- in_data  input  N*W  input words; port i occupies bits [i*W +: W].
- in_dest  input  N*SEL_W  destination output index per input; port i occupies [i*SEL_W +: SEL_W].
- in_valid  input  N  input i presents a word.
- in_ready  output  N  input i's word is accepted at this clock edge.
- out_data  output  N*W  registered output words.
- out_src  output  N*SEL_W  index of the input that supplied out_data[j].
- out_valid  output  N  output j holds a word.
- out_ready  input  N  downstream consumes output j at this edge.

Behaviour:
- Reset (rst=1 at a clock edge):
  - out_valid, out_data, out_src and every round-robin pointer ptr[j] are cleared to 0.
  - in_ready is forced to 0 combinationally while rst=1.
- Request: req[j][i] = in_valid[i] && (in_dest[i] == j). Each input targets exactly one output, so an input receives at most one grant.
- Slot free: free[j] = !out_valid[j] || out_ready[j]. This is pass-through, so full throughput is 1 word/cycle/output.
- Arbitration, combinational, per output:
  - If free[j] and any req[j][*], grant the first requesting input searching i = ptr[j], ptr[j]+1, ... with mod-N wrap.
  - With no request, or when not free, there is no grant.
- in_ready[i] = 1 iff input i is granted this cycle and rst=0. A transfer occurs on in_valid && in_ready.
- Clock edge, per output j:
  - Grant to input g: out_data[j] <= in_data[g], out_src[j] <= g, out_valid[j] <= 1, ptr[j] <= g+1 (wraps N-1 -> 0).
  - No grant and out_ready[j]: out_valid[j] <= 0. out_data and out_src hold their last value.
  - Otherwise: all state holds, including ptr[j].
- Latency: 1 cycle from accepted input to out_valid.
- Ordering: the order is preserved per input-output pair.
- Simultaneous events:
  - Pop and push on the same output in the same cycle replaces the word with no bubble.
  - Multiple outputs may grant in the same cycle; up to N transfers per cycle when destinations form a permutation.
- Backpressure: while out_valid[j]=1 and out_ready[j]=0, every requester for j sees in_ready=0, and the output register and ptr[j] are frozen.
- Source rule: sources keep in_data/in_dest stable while in_valid && !in_ready. A source changing in_dest while stalled is legal and simply re-targets the request.
- Reset mid-operation: words held in output registers are discarded, and pending requests are dropped for that cycle. Arbitration restarts from pointer 0 on the first cycle after rst falls.
- Out-of-range index: not possible, since N = 2**SEL_W.

Test Plan:
- Reset: rst=1 for 2 cycles with all in_valid=1 -> in_ready=0000, out_valid=0000, out_data=0, out_src=0 after the edge.
- Permutation (SEL_W=2, W=4):
  - Stimulus: in_data = 0001, 0010, 0100, 1000 to dest 3, 2, 1, 0; all valid; out_ready=1111.
  - Response: in_ready=1111 the same cycle. Next cycle out_data0=1000, out_data1=0100, out_data2=0010, out_data3=0001; out_src0..3 = 3, 2, 1, 0; out_valid=1111.
- Contention: all four inputs dest 0, held valid, out_ready0=1 -> one grant per cycle; out_src0 sequence 0, 1, 2, 3, then 0 again (wrap); out_valid0 stays high continuously.
- Fairness:
  - Setup: after input 0 has just won output 1, ptr[1]=1.
  - Stimulus: inputs 0 and 2 request output 1.
  - Response: input 2 is granted first, then input 0 on the next cycle.
- Backpressure: out_valid0=1 and out_ready0=0 for 3 cycles with input 1 requesting dest 0 -> in_ready1=0 and out_data0 held. Raise out_ready0 -> in_ready1=1 the same cycle, and out_src0=1 on the next edge.
- Reset mid-stream: during the contention test, assert rst for 1 cycle -> out_valid=0000 next edge. After rst falls, the first grant on output 0 goes to input 0.
